mul8_nibble_sched: RTL and testbench



---
 rtl/mul8_nibble_sched.sv | 135 +++++++++++++
 tb/tb_mul8_nibble_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_nibble_sched.sv
// rtl/mul8_nibble_sched.sv - unsigned 8x8 multiply scheduled over one shared 4x4 multiplier
module mul8_nibble_sched #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [3:0]  mx,
    output logic [3:0]  my,
    input  logic [7:0]  mz
);

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t      r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;

    logic        w_accept;
    logic        w_retire;
    logic        w_last;
    logic [15:0] w_term;
    logic [15:0] w_sum;

    assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_retire = (r_state == DONE) & out_ready;
    assign w_last   = (r_cnt == LAST);
    assign w_sum    = r_acc + w_term;

    // Nibble pair and partial-product weight for the current pass
    always_comb begin
        mx     = 4'h0;
        my     = 4'h0;
        w_term = 16'h0000;
        case (r_state)
            P0: begin
                mx     = r_a[3:0];
                my     = r_b[3:0];
                w_term = {8'h00, mz};
            end
            P1: begin
                mx     = r_a[3:0];
                my     = r_b[7:4];
                w_term = {4'h0, mz, 4'h0};
            end
            P2: begin
                mx     = r_a[7:4];
                my     = r_b[3:0];
                w_term = {4'h0, mz, 4'h0};
            end
            P3: begin
                mx     = r_a[7:4];
                my     = r_b[7:4];
                w_term = {mz, 8'h00};
            end
            default: begin
                mx     = 4'h0;
                my     = 4'h0;
                w_term = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_acc     <= 16'h0000;
            r_cnt     <= 4'h0;
            product   <= 16'h0000;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_retire)
                        out_valid <= 1'b0;
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= 16'h0000;
                        r_cnt   <= 4'h0;
                        busy    <= 1'b1;
                        r_state <= P0;
                    end else if (w_retire) begin
                        r_state <= IDLE;
                    end
                end
                P0, P1, P2: begin
                    if (w_last) begin
                        r_acc <= w_sum;
                        r_cnt <= 4'h0;
                        case (r_state)
                            P0:      r_state <= P1;
                            P1:      r_state <= P2;
                            default: r_state <= P3;
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 4'h1;
                    end
                end
                P3: begin
                    if (w_last) begin
                        r_acc     <= w_sum;
                        r_cnt     <= 4'h0;
                        product   <= w_sum;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'h1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_nibble_sched.sv
// tb/tb_mul8_nibble_sched.sv - directed self-checking bench for mul8_nibble_sched
module tb_mul8_nibble_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, busy1;
    logic [7:0]  a1 = 8'h00, b1 = 8'h00, mz1;
    logic [15:0] product1;
    logic [3:0]  mx1, my1;

    logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0, busy3;
    logic [7:0]  a3 = 8'h00, b3 = 8'h00, mz3;
    logic [15:0] product3;
    logic [3:0]  mx3, my3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mz1 = {4'h0, mx1} * {4'h0, my1};
    assign mz3 = {4'h0, mx3} * {4'h0, my3};

    mul8_nibble_sched #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .product(product1),
        .busy(busy1), .mx(mx1), .my(my1), .mz(mz1)
    );

    mul8_nibble_sched #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .a(a3), .b(b3),
        .out_valid(out_valid3), .out_ready(out_ready3), .product(product3),
        .busy(busy3), .mx(mx3), .my(my3), .mz(mz3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid1, busy1, in_ready1, product1, mx1, my1} !== {1'b0, 1'b0, 1'b1, 16'h0, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_dut1 got ov=%b busy=%b ir=%b p=%h mx=%h my=%h exp ov=0 busy=0 ir=1 p=0000 mx=0 my=0",
                     out_valid1, busy1, in_ready1, product1, mx1, my1);
        end
        n_checks++;
        if ({out_valid3, busy3, in_ready3, product3, mx3, my3} !== {1'b0, 1'b0, 1'b1, 16'h0, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_dut3 got ov=%b busy=%b ir=%b p=%h exp ov=0 busy=0 ir=1 p=0000",
                     out_valid3, busy3, in_ready3, product3);
        end
    endtask

    // Accept a/b on dut1, check every pass pair, then check the result in DONE
    task automatic test_product(input string name, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] exp_p, input logic [31:0] exp_pairs);
        a1 = av;
        b1 = bv;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        a1 = 8'h5A;
        b1 = 8'hC3;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if ({mx1, my1, busy1, out_valid1, in_ready1} !== {exp_pairs[31-8*p -: 8], 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL %s_pass%0d got mx=%h my=%h busy=%b ov=%b ir=%b exp pair=%h busy=1 ov=0 ir=0",
                         name, p, mx1, my1, busy1, out_valid1, in_ready1, exp_pairs[31-8*p -: 8]);
            end
            step();
        end
        n_checks++;
        if ({out_valid1, product1, busy1, mx1, my1} !== {1'b1, exp_p, 1'b0, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL %s_done got ov=%b p=%h busy=%b mx=%h my=%h exp ov=1 p=%h busy=0 mx=0 my=0",
                     name, out_valid1, product1, busy1, mx1, my1, exp_p);
        end
    endtask

    task automatic test_retire(input logic [15:0] exp_p);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        #1;
        n_checks++;
        if ({out_valid1, product1, in_ready1, busy1} !== {1'b0, exp_p, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL retire got ov=%b p=%h ir=%b busy=%b exp ov=0 p=%h ir=1 busy=0",
                     out_valid1, product1, in_ready1, busy1, exp_p);
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 7; c++) begin
            n_checks++;
            if ({out_valid1, product1, in_ready1} !== {1'b1, 16'h03A8, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_c%0d got ov=%b p=%h ir=%b exp ov=1 p=03a8 ir=0",
                         c, out_valid1, product1, in_ready1);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        a1 = 8'h0F;
        b1 = 8'h10;
        in_valid1 = 1'b1;
        out_ready1 = 1'b1;
        #1;
        n_checks++;
        if (in_ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_in_ready got %b exp 1", in_ready1);
        end
        step();
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        n_checks++;
        if ({out_valid1, busy1, mx1, my1} !== {1'b0, 1'b1, 4'hF, 4'h0}) begin
            n_fail++;
            $display("FAIL b2b_accept got ov=%b busy=%b mx=%h my=%h exp ov=0 busy=1 mx=f my=0",
                     out_valid1, busy1, mx1, my1);
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_early_valid_c%0d got %b exp 0", c, out_valid1);
            end
            step();
        end
        n_checks++;
        if ({out_valid1, product1} !== {1'b1, 16'h00F0}) begin
            n_fail++;
            $display("FAIL b2b_result got ov=%b p=%h exp ov=1 p=00f0", out_valid1, product1);
        end
        test_retire(16'h00F0);
    endtask

    task automatic test_reset_mid();
        a1 = 8'hFF;
        b1 = 8'hFF;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        step();
        n_checks++;
        if ({busy1, mx1, my1} !== {1'b1, 4'hF, 4'hF}) begin
            n_fail++;
            $display("FAIL mid_in_p2 got busy=%b mx=%h my=%h exp busy=1 mx=f my=f", busy1, mx1, my1);
        end
        rst = 1'b1;
        in_valid1 = 1'b1;
        out_ready1 = 1'b1;
        step();
        rst = 1'b0;
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        #1;
        n_checks++;
        if ({busy1, out_valid1, product1, mx1, my1, in_ready1} !== {1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset got busy=%b ov=%b p=%h mx=%h my=%h ir=%b exp busy=0 ov=0 p=0000 mx=0 my=0 ir=1",
                     busy1, out_valid1, product1, mx1, my1, in_ready1);
        end
        test_product("after_reset", 8'h03, 8'h05, 16'h000F, {8'h35, 8'h30, 8'h05, 8'h00});
        test_retire(16'h000F);
    endtask

    task automatic test_settle3();
        logic [31:0] pairs;
        pairs = {8'h7C, 8'h73, 8'hAC, 8'hA3};
        a3 = 8'hA7;
        b3 = 8'h3C;
        in_valid3 = 1'b1;
        step();
        in_valid3 = 1'b0;
        a3 = 8'h00;
        b3 = 8'h00;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if ({mx3, my3, out_valid3, busy3} !== {pairs[31-8*p -: 8], 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL settle3_p%0d_c%0d got mx=%h my=%h ov=%b busy=%b exp pair=%h ov=0 busy=1",
                             p, c, mx3, my3, out_valid3, busy3, pairs[31-8*p -: 8]);
                end
                step();
            end
        end
        n_checks++;
        if ({out_valid3, product3, busy3} !== {1'b1, 16'h2724, 1'b0}) begin
            n_fail++;
            $display("FAIL settle3_result got ov=%b p=%h busy=%b exp ov=1 p=2724 busy=0",
                     out_valid3, product3, busy3);
        end
        out_ready3 = 1'b1;
        step();
        out_ready3 = 1'b0;
        n_checks++;
        if ({out_valid3, product3} !== {1'b0, 16'h2724}) begin
            n_fail++;
            $display("FAIL settle3_retire got ov=%b p=%h exp ov=0 p=2724", out_valid3, product3);
        end
    endtask

    initial begin
        test_reset();
        test_product("max", 8'hFF, 8'hFF, 16'hFE01, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        test_retire(16'hFE01);
        test_product("zero", 8'h00, 8'hA5, 16'h0000, {8'h05, 8'h0A, 8'h05, 8'h0A});
        test_retire(16'h0000);
        test_product("mixed", 8'h12, 8'h34, 16'h03A8, {8'h24, 8'h23, 8'h14, 8'h13});
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_settle3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
